button_debounce_multi: RTL and testbench



---
 rtl/button_debounce_multi.sv | 120 ++++++++++++
 tb/tb_button_debounce_multi.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce_multi.sv
// button_debounce_multi
//   N-channel push-button conditioner. Each channel has its own synchroniser,
//   stable-time filter, debounced level and press / release / long-press
//   pulses. Channels share nothing except the clock and reset.
//
// Parameters
//   N_CH          number of independent channels (>=1)
//   SYNC_STAGES   synchroniser flops per channel (>=2)
//   STABLE_CYCLES cycles a new level must persist before acceptance (>=2)
//   LONG_CYCLES   cycles the level must stay pressed before long_pulse (>=2)
//   ACTIVE_LOW    1 = raw input reads 0 when pressed
//
// Ports
//   clk            system clock
//   rst            synchronous, active-high reset
//   btn_in         raw asynchronous button inputs, one bit per channel
//   btn_level      debounced level, 1 = pressed (polarity corrected)
//   press_pulse    one-cycle pulse on an accepted press
//   release_pulse  one-cycle pulse on an accepted release
//   long_pulse     one-cycle pulse once per press held for LONG_CYCLES
module button_debounce_multi #(
  parameter int N_CH          = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1000000,
  parameter int LONG_CYCLES   = 50000000,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_pulse
);

  localparam int SW = $clog2(STABLE_CYCLES) + 1;
  localparam int HW = $clog2(LONG_CYCLES) + 1;

  localparam logic          IDLE_RAW    = (ACTIVE_LOW != 0);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] LONG_SAT    = HW'(LONG_CYCLES);

  // Hold counter step: cleared while released, counts while pressed and
  // parks at LONG_CYCLES so the long pulse cannot repeat within one press.
  function automatic logic [HW-1:0] hold_next(input logic lvl, input logic [HW-1:0] h);
    if (!lvl)
      return '0;
    if (h < LONG_LAST)
      return h + HW'(1);
    return LONG_SAT;
  endfunction

  function automatic logic long_fire(input logic lvl, input logic [HW-1:0] h);
    return lvl && (h == LONG_LAST);
  endfunction

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   s_p1;
    logic [SW-1:0]          stab_cnt;
    logic [HW-1:0]          hold_cnt;
    logic                   level_p2;
    logic                   press_p2;
    logic                   release_p2;
    logic                   long_p3;

    // Stage 0: synchroniser, reset to the released raw level
    always_ff @(posedge clk) begin
      if (rst)
        sync_p0 <= {SYNC_STAGES{IDLE_RAW}};
      else
        sync_p0 <= {sync_p0[SYNC_STAGES-2:0], btn_in[ch]};
    end

    // Stage 1: polarity correction, 1 = pressed
    assign s_p1 = sync_p0[SYNC_STAGES-1] ^ IDLE_RAW;

    // Stage 2: stable-time filter and edge pulses
    always_ff @(posedge clk) begin
      if (rst) begin
        stab_cnt   <= '0;
        level_p2   <= 1'b0;
        press_p2   <= 1'b0;
        release_p2 <= 1'b0;
      end else begin
        press_p2   <= 1'b0;
        release_p2 <= 1'b0;
        if (s_p1 == level_p2) begin
          stab_cnt <= '0;
        end else if (stab_cnt == STABLE_LAST) begin
          stab_cnt   <= '0;
          level_p2   <= s_p1;
          press_p2   <= s_p1;
          release_p2 <= ~s_p1;
        end else begin
          stab_cnt <= stab_cnt + SW'(1);
        end
      end
    end

    // Stage 3: long-press detection on the debounced level
    always_ff @(posedge clk) begin
      if (rst) begin
        hold_cnt <= '0;
        long_p3  <= 1'b0;
      end else begin
        hold_cnt <= hold_next(level_p2, hold_cnt);
        long_p3  <= long_fire(level_p2, hold_cnt);
      end
    end

    assign btn_level[ch]     = level_p2;
    assign press_pulse[ch]   = press_p2;
    assign release_pulse[ch] = release_p2;
    assign long_pulse[ch]    = long_p3;
  end

endmodule

// File: tb/tb_button_debounce_multi.sv
module tb_button_debounce_multi;

  localparam int N      = 4;
  localparam int S      = 2;
  localparam int STABLE = 8;
  localparam int LONG   = 32;
  localparam int NM     = N + 1;   // model channel N is the active-low instance

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn;
  logic [N-1:0] lvl, prs, rel, lng;
  logic         btn_al;
  logic         lvl_al, prs_al, rel_al, lng_al;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  button_debounce_multi #(
    .N_CH(N), .SYNC_STAGES(S), .STABLE_CYCLES(STABLE), .LONG_CYCLES(LONG), .ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn),
    .btn_level(lvl), .press_pulse(prs), .release_pulse(rel), .long_pulse(lng)
  );

  button_debounce_multi #(
    .N_CH(1), .SYNC_STAGES(S), .STABLE_CYCLES(STABLE), .LONG_CYCLES(LONG), .ACTIVE_LOW(1)
  ) dut_al (
    .clk(clk), .rst(rst), .btn_in(btn_al),
    .btn_level(lvl_al), .press_pulse(prs_al), .release_pulse(rel_al), .long_pulse(lng_al)
  );

  // Reference model: edges counted since the last reset edge; the filter
  // accepts when the last STABLE synchronised samples all differ from the
  // current level; a long press is simply "LONG edges after the press edge
  // with the level still held".
  int t;
  bit samp [NM][16];
  bit sv   [NM][16];
  bit m_lvl[NM], m_prs[NM], m_rel[NM], m_lng[NM];
  int press_t[NM];

  task automatic model_edge();
    bit p, s_now, acc;
    if (rst) begin
      t = 0;
      for (int c = 0; c < NM; c++) begin
        m_lvl[c] = 0; m_prs[c] = 0; m_rel[c] = 0; m_lng[c] = 0; press_t[c] = -1;
      end
      return;
    end
    t++;
    for (int c = 0; c < NM; c++) begin
      p = (c < N) ? btn[c] : ~btn_al;
      s_now = (t - S >= 1) ? samp[c][(t - S) % 16] : 1'b0;
      samp[c][t % 16] = p;
      sv[c][t % 16]   = s_now;
      m_prs[c] = 0;
      m_rel[c] = 0;
      m_lng[c] = m_lvl[c] && (press_t[c] >= 0) && (t == press_t[c] + LONG);
      acc = (t >= STABLE);
      for (int j = 0; j < STABLE; j++)
        if (acc && sv[c][(t - j) % 16] == m_lvl[c]) acc = 0;
      if (acc) begin
        m_lvl[c]   = s_now;
        m_prs[c]   = s_now;
        m_rel[c]   = !s_now;
        press_t[c] = s_now ? t : -1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [N-1:0] el, ep, er, eg;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int c = 0; c < N; c++) begin
      el[c] = m_lvl[c]; ep[c] = m_prs[c]; er[c] = m_rel[c]; eg[c] = m_lng[c];
    end
    chk("m_level",   lvl, el);
    chk("m_press",   prs, ep);
    chk("m_release", rel, er);
    chk("m_long",    lng, eg);
    chk("m_al_level",   lvl_al, m_lvl[N]);
    chk("m_al_press",   prs_al, m_prs[N]);
    chk("m_al_release", rel_al, m_rel[N]);
    chk("m_al_long",    lng_al, m_lng[N]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int np, at, nl, nr, any;
  int rl[NM];
  bit rv[NM];

  initial begin
    rst = 1'b1; btn = '0; btn_al = 1'b1;
    idle(3);
    chk("rst_level", {lvl, lvl_al}, 0);
    chk("rst_pulses", {prs, rel, lng, prs_al, rel_al, lng_al}, 0);
    rst = 1'b0;
    idle(5);
    chk("idle_outputs", {lvl, prs, rel, lng, lvl_al, prs_al, rel_al, lng_al}, 0);

    // clean press and release on channel 0
    btn[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("clean_press0", prs[0], i == 9);
      chk("clean_level0", lvl[0], i >= 9);
      chk("clean_others", {prs[3:1], lvl[3:1]}, 0);
    end
    btn[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("clean_release0", rel[0], i == 9);
      chk("clean_nopress0", prs[0], 0);
    end

    // bounce on channel 1: toggles every 3 cycles, last rise sampled at i=27
    np = 0; at = -1; nr = 0;
    for (int i = 0; i < 50; i++) begin
      btn[1] = (i < 30) ? (((i / 3) % 2) == 1) : 1'b1;
      step();
      if (prs[1]) begin np++; at = i; end
      if (rel[1]) nr++;
    end
    chk("bounce_press_count", np, 1);
    chk("bounce_press_edge", at, 36);
    chk("bounce_no_release", nr, 0);
    btn[1] = 1'b0;
    idle(12);

    // glitch on channel 2: 7 cycles high is one short of acceptance
    any = 0;
    btn[2] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      any |= int'(lvl[2] | prs[2] | rel[2] | lng[2]);
    end
    btn[2] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      any |= int'(lvl[2] | prs[2] | rel[2] | lng[2]);
    end
    chk("glitch_quiet", any, 0);
    chk("glitch_cnt_zero", dut.g_ch[2].stab_cnt, 0);

    // long press on channel 3: 60 cycles held
    btn[3] = 1'b1;
    nl = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      chk("long_press3", prs[3], i == 9);
      chk("long_pulse3", lng[3], i == 41);
      if (lng[3]) nl++;
    end
    chk("long_once", nl, 1);
    btn[3] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("long_release3", rel[3], i == 9);
      chk("long_norepeat", lng[3], 0);
    end

    // short hold on channel 3: 30 cycles, no long pulse
    btn[3] = 1'b1;
    nl = 0; nr = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (lng[3]) nl++;
    end
    btn[3] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (lng[3]) nl++;
      if (rel[3]) nr++;
    end
    chk("short_no_long", nl, 0);
    chk("short_release", nr, 1);

    // all channels pressed on the same edge
    btn = '1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("concurrent_press", prs, (i == 9) ? 4'hF : 4'h0);
    end
    btn = '0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("concurrent_release", rel, (i == 9) ? 4'hF : 4'h0);
    end

    // reset in the middle of a press discards all progress
    btn[0] = 1'b1;
    idle(6);
    rst = 1'b1;
    step();
    chk("midrst_outputs", {lvl, prs, rel, lng}, 0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("midrst_press0", prs[0], i == 9);
    end
    btn[0] = 1'b0;
    idle(12);

    // active-low instance
    btn_al = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("al_press", prs_al, i == 9);
      chk("al_level", lvl_al, i >= 9);
    end
    btn_al = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("al_release", rel_al, i == 9);
    end

    // randomized run lengths: mixes glitches, bounces, short and long holds
    for (int c = 0; c < NM; c++) begin rl[c] = 0; rv[c] = 0; end
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NM; c++) begin
        if (rl[c] == 0) begin
          rv[c] = $urandom_range(0, 1);
          rl[c] = $urandom_range(1, 45);
        end
        rl[c]--;
        if (c < N) btn[c] = rv[c];
        else       btn_al = ~rv[c];
      end
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
